// File: rtl/divider_arbiter.sv
// divider_arbiter: shares one iterative divider between NUM_REQ requesters.
// Requesters are granted round-robin. One division is in flight at a time,
// and the quotient/remainder are routed back to the requester that owns it.
// Optional build macro DIVARB_ZERO_CHECK_EN: when it is defined, a zero
// divisor is answered locally with an error flag and the divider is not
// started. When it is undefined, zero divisors go to the divider unchanged
// and resp_error stays 0.

module divider_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
    input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]         resp_quotient,
    output logic [WIDTH-1:0]         resp_remainder,
    output logic                     resp_error,
    output logic [WIDTH-1:0]         div_dividend,
    output logic [WIDTH-1:0]         div_divisor,
    output logic                     div_data_in_valid,
    input  logic                     div_busy,
    input  logic [WIDTH-1:0]         div_quotient,
    input  logic [WIDTH-1:0]         div_remainder,
    input  logic                     div_data_out_valid
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   pick;
    logic               pick_found;
    logic [PTR_W:0]     search_idx;
    logic [PTR_W-1:0]   slot;
    logic [WIDTH-1:0]   pick_dividend;
    logic [WIDTH-1:0]   pick_divisor;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [NUM_REQ-1:0] owner_onehot;

    // Round-robin search: the first valid requester starting at rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        search_idx = '0;
        slot       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            search_idx = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
            if (search_idx >= (PTR_W + 1)'(NUM_REQ)) begin
                search_idx = search_idx - (PTR_W + 1)'(NUM_REQ);
            end
            slot = search_idx[PTR_W-1:0];
            if (!pick_found && req_valid[slot]) begin
                pick_found = 1'b1;
                pick       = slot;
            end
        end
    end

    // Operand mux for the candidate requester, plus the one-hot forms of pick and owner
    always_comb begin
        pick_dividend = '0;
        pick_divisor  = '0;
        pick_onehot   = '0;
        owner_onehot  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == pick) begin
                pick_dividend  = req_dividend[i*WIDTH +: WIDTH];
                pick_divisor   = req_divisor[i*WIDTH +: WIDTH];
                pick_onehot[i] = 1'b1;
            end
            if (PTR_W'(i) == owner) begin
                owner_onehot[i] = 1'b1;
            end
        end
    end

    // Grant is combinational so that a request is accepted in the same cycle it is first seen in IDLE
    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE && pick_found) begin
            req_ready = pick_onehot;
        end
    end

    // Main control FSM; every output except req_ready is registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            owner             <= '0;
            resp_valid        <= '0;
            resp_quotient     <= '0;
            resp_remainder    <= '0;
            resp_error        <= 1'b0;
            div_dividend      <= '0;
            div_divisor       <= '0;
            div_data_in_valid <= 1'b0;
        end else begin
            resp_valid        <= '0;
            div_data_in_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner <= pick;
`ifdef DIVARB_ZERO_CHECK_EN
                        if (pick_divisor == '0) begin
                            resp_valid     <= pick_onehot;
                            resp_quotient  <= '1;
                            resp_remainder <= pick_dividend;
                            resp_error     <= 1'b1;
                            state          <= RESPOND;
                        end else begin
                            div_dividend <= pick_dividend;
                            div_divisor  <= pick_divisor;
                            state        <= ISSUE;
                        end
`else
                        div_dividend <= pick_dividend;
                        div_divisor  <= pick_divisor;
                        state        <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    if (!div_busy) begin
                        div_data_in_valid <= 1'b1;
                        state             <= WAIT;
                    end
                end
                WAIT: begin
                    if (div_data_out_valid) begin
                        resp_valid     <= owner_onehot;
                        resp_quotient  <= div_quotient;
                        resp_remainder <= div_remainder;
                        resp_error     <= 1'b0;
                        state          <= RESPOND;
                    end
                end
                RESPOND: begin
                    rr_ptr <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_arbiter.sv
// tb_divider_arbiter: self-checking bench for divider_arbiter. It contains a
// behavioural divider with a fixed latency and a round-robin reference model.
// Define DIVARB_ZERO_CHECK_EN for this bench and for the RTL together.

module tb_divider_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LAT = 8;

`ifdef DIVARB_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_dividend;
    logic [N*W-1:0] req_divisor;
    logic [N-1:0]   resp_valid;
    logic [W-1:0]   resp_quotient;
    logic [W-1:0]   resp_remainder;
    logic           resp_error;
    logic [W-1:0]   div_dividend;
    logic [W-1:0]   div_divisor;
    logic           div_data_in_valid;
    logic           div_busy;
    logic [W-1:0]   div_quotient = '0;
    logic [W-1:0]   div_remainder = '0;
    logic           div_data_out_valid = 1'b0;

    logic         force_busy = 1'b0;
    int           div_cnt = 0;
    logic [W-1:0] lat_a = '0;
    logic [W-1:0] lat_b = '0;
    int           in_pulses = 0;
    int           resp_pulses = 0;
    int           errors = 0;
    int           checks = 0;
    int           rr_model = 0;
    logic [W-1:0] dvd [N];
    logic [W-1:0] dvs [N];

    always #5 clk = ~clk;

    divider_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_dividend       (req_dividend),
        .req_divisor        (req_divisor),
        .resp_valid         (resp_valid),
        .resp_quotient      (resp_quotient),
        .resp_remainder     (resp_remainder),
        .resp_error         (resp_error),
        .div_dividend       (div_dividend),
        .div_divisor        (div_divisor),
        .div_data_in_valid  (div_data_in_valid),
        .div_busy           (div_busy),
        .div_quotient       (div_quotient),
        .div_remainder      (div_remainder),
        .div_data_out_valid (div_data_out_valid)
    );

    function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == '0) ? '1 : a / b;
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == '0) ? a : a % b;
    endfunction

    // Behavioural divider: busy for LAT cycles after a start, then a one-cycle result pulse
    always @(posedge clk) begin
        div_data_out_valid <= 1'b0;
        if (div_cnt > 0) begin
            div_cnt <= div_cnt - 1;
            if (div_cnt == 1) begin
                div_data_out_valid <= 1'b1;
                div_quotient       <= ref_q(lat_a, lat_b);
                div_remainder      <= ref_r(lat_a, lat_b);
            end
        end else if (div_data_in_valid) begin
            div_cnt <= LAT;
            lat_a   <= div_dividend;
            lat_b   <= div_divisor;
        end
    end

    assign div_busy = force_busy || (div_cnt != 0);

    // Count divider start pulses and response pulses
    always @(posedge clk) begin
        if (div_data_in_valid) in_pulses <= in_pulses + 1;
        if (resp_valid != '0) resp_pulses <= resp_pulses + 1;
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            req_dividend[i*W +: W] = dvd[i];
            req_divisor[i*W +: W]  = dvs[i];
        end
        req_valid = mask;
    endtask

    function automatic int model_owner(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(rr_model + k) % N]) return (rr_model + k) % N;
        end
        return 0;
    endfunction

    // Drive a request mask, wait (bounded) for the grant, check it, and let it be accepted
    task automatic txnGrant(input logic [N-1:0] mask, input bit hold, input string tag, output int owner);
        bit seen;
        owner = model_owner(mask);
        applyStimulus(mask);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            #1;
            if (req_ready != '0) seen = 1'b1;
            else @(negedge clk);
        end
        checkOutput({tag, "_grant"}, req_ready, N'(1) << owner);
        @(posedge clk);
        #1;
        if (!hold) req_valid = '0;
    endtask

    // Wait (bounded) for the owner's response and check the result and the pulse width
    task automatic txnResponse(input int owner, input string tag);
        bit got;
        logic [W-1:0] a, b;
        a = dvd[owner];
        b = dvs[owner];
        got = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            #1;
            got = (resp_valid != '0);
        end
        checkOutput({tag, "_resp_valid"}, resp_valid, N'(1) << owner);
        checkOutput({tag, "_quotient"}, resp_quotient, ref_q(a, b));
        checkOutput({tag, "_remainder"}, resp_remainder, ref_r(a, b));
        checkOutput({tag, "_error"}, resp_error, ZC && (b == '0));
        @(negedge clk);
        #1;
        checkOutput({tag, "_resp_drop"}, resp_valid, '0);
        rr_model = (owner + 1) % N;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, req_ready, '0);
        checkOutput({tag, "_resp_valid"}, resp_valid, '0);
        checkOutput({tag, "_resp_quotient"}, resp_quotient, '0);
        checkOutput({tag, "_resp_remainder"}, resp_remainder, '0);
        checkOutput({tag, "_resp_error"}, resp_error, '0);
        checkOutput({tag, "_div_in_valid"}, div_data_in_valid, '0);
        checkOutput({tag, "_div_dividend"}, div_dividend, '0);
        checkOutput({tag, "_div_divisor"}, div_divisor, '0);
    endtask

    initial begin
        int owner;
        int p0;
        int r0;
        bit seen;

        for (int i = 0; i < N; i++) begin
            dvd[i] = '0;
            dvs[i] = '0;
        end
        rst = 1'b1;
        applyStimulus(4'b1111);
        repeat (3) @(negedge clk);
        #1;
        checkResetOutputs("reset");
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Fairness: all requesters held valid, grants must rotate 0,1,2,3,0,1
        for (int i = 0; i < N; i++) begin
            dvd[i] = 32'd1000 + 32'(i * 37);
            dvs[i] = 32'd3 + 32'(i);
        end
        for (int t = 0; t < 6; t++) begin
            txnGrant(4'b1111, 1'b1, $sformatf("fair%0d", t), owner);
            txnResponse(owner, $sformatf("fair%0d", t));
        end
        req_valid = '0;
        @(negedge clk);

        // Single request from requester 0
        dvd[0] = 32'd50_000_000;
        dvs[0] = 32'd440;
        txnGrant(4'b0001, 1'b0, "single", owner);
        txnResponse(owner, "single");

        // Busy stall: divider busy for 20 cycles while the block sits in ISSUE
        force_busy = 1'b1;
        dvd[2] = 32'd123456;
        dvs[2] = 32'd789;
        txnGrant(4'b0100, 1'b0, "stall", owner);
        p0 = in_pulses;
        repeat (20) @(negedge clk);
        checkOutput("stall_no_start", in_pulses - p0, 0);
        force_busy = 1'b0;
        txnResponse(owner, "stall");
        checkOutput("stall_one_start", in_pulses - p0, 1);

        // Reset in the middle of a division aborts it silently
        dvd[0] = 32'd999999;
        dvs[0] = 32'd13;
        p0 = in_pulses;
        txnGrant(4'b0001, 1'b0, "abort", owner);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            seen = (in_pulses != p0);
        end
        checkOutput("abort_started", seen, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checkResetOutputs("abort");
        @(negedge clk);
        rst = 1'b0;
        rr_model = 0;
        r0 = resp_pulses;
        repeat (30) @(negedge clk);
        checkOutput("abort_no_resp", resp_pulses - r0, 0);
        dvd[2] = 32'd100;
        dvs[2] = 32'd7;
        txnGrant(4'b0100, 1'b0, "fresh", owner);
        txnResponse(owner, "fresh");

        // Wrap/skip: pointer past the last requester, only requester 1 valid
        dvd[1] = 32'd65535;
        dvs[1] = 32'd255;
        txnGrant(4'b0010, 1'b0, "wrap", owner);
        txnResponse(owner, "wrap");
        dvd[3] = 32'd4000;
        dvs[3] = 32'd9;
        txnGrant(4'b1010, 1'b0, "after_wrap", owner);
        txnResponse(owner, "after_wrap");

        // Zero divisor handling
        dvd[1] = 32'd7;
        dvs[1] = 32'd0;
        p0 = in_pulses;
        txnGrant(4'b0010, 1'b0, "zero", owner);
        txnResponse(owner, "zero");
        checkOutput("zero_div_starts", in_pulses - p0, ZC ? 0 : 1);

        // Random masks and operands, occasionally with a zero divisor
        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < N; i++) begin
                dvd[i] = $urandom;
                dvs[i] = ($urandom_range(0, 7) == 0) ? 32'd0 :
                         (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
            end
            txnGrant(4'($urandom_range(1, 15)), 1'b0, $sformatf("rand%0d", t), owner);
            txnResponse(owner, $sformatf("rand%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
